// File: rtl/tribuf_pkg.sv
// Shared types and reset constants for the triple-buffer index controller.
package tribuf_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam buf_idx_t WR_IDX_RST  = 2'd0;
    localparam buf_idx_t RDY_IDX_RST = 2'd1;
    localparam buf_idx_t RD_IDX_RST  = 2'd2;

endpackage

// File: rtl/tribuf_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module tribuf_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tribuf_ctrl.sv
// Triple-buffer ownership controller: rotates writer/ready/reader buffer indices.
// Statistics counters exist only when TRIBUF_STATS_EN is defined.
//
// state    | meaning
// ST_IDLE  | disabled, indices parked at 0/1/2, pulses ignored
// ST_PRIME | enabled, waiting for the reader's first fresh frame
// ST_RUN   | steady streaming, stale reader swaps count as repeats
module tribuf_ctrl
    import tribuf_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_frame_bytes,
    input  logic              stat_clr,
    input  logic              wr_done,
    input  logic              rd_swap,
    output logic [1:0]        wr_idx,
    output logic [1:0]        rd_idx,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  rep_cnt
);

    state_t            state_q, state_d;
    buf_idx_t          wr_q, wr_d, rdy_q, rdy_d, rd_q, rd_d;
    logic              rdy_new_q, rdy_new_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;
    logic              drop_inc, rep_inc;

    // Index is only ever 0..2, so the multiply reduces to a shift/mux.
    function automatic logic [ADDR_W-1:0] buf_offset(input buf_idx_t idx,
                                                     input logic [ADDR_W-1:0] stride);
        case (idx)
            2'd0:    return '0;
            2'd1:    return stride;
            default: return stride << 1;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        rdy_d      = rdy_q;
        rd_d       = rd_q;
        rdy_new_d  = rdy_new_q;
        rd_valid_d = rd_valid_q;

        if (!cfg_en || state_q == ST_IDLE) begin
            wr_d       = WR_IDX_RST;
            rdy_d      = RDY_IDX_RST;
            rd_d       = RD_IDX_RST;
            rdy_new_d  = 1'b0;
            rd_valid_d = 1'b0;
            state_d    = cfg_en ? ST_PRIME : ST_IDLE;
        end else begin
            if (wr_done && rd_swap) begin
                rd_d       = wr_q;
                wr_d       = rdy_q;
                rdy_d      = rd_q;
                rdy_new_d  = 1'b0;
                rd_valid_d = 1'b1;
            end else if (wr_done) begin
                wr_d      = rdy_q;
                rdy_d     = wr_q;
                rdy_new_d = 1'b1;
            end else if (rd_swap && rdy_new_q) begin
                rd_d       = rdy_q;
                rdy_d      = rd_q;
                rdy_new_d  = 1'b0;
                rd_valid_d = 1'b1;
            end
            if (state_q == ST_PRIME && rd_swap && rdy_new_q)
                state_d = ST_RUN;
        end
    end

    assign drop_inc = cfg_en && (state_q != ST_IDLE) && wr_done && !rd_swap && rdy_new_q;
    assign rep_inc  = cfg_en && (state_q == ST_RUN) && rd_swap && !wr_done && !rdy_new_q;

    // Bases follow the registered indices, giving two cycles from pulse to base.
    assign wr_base_d = cfg_base + buf_offset(wr_q, cfg_frame_bytes);
    assign rd_base_d = cfg_base + buf_offset(rd_q, cfg_frame_bytes);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_IDLE;
            wr_q       <= WR_IDX_RST;
            rdy_q      <= RDY_IDX_RST;
            rd_q       <= RD_IDX_RST;
            rdy_new_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_base_q  <= '0;
            rd_base_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            rdy_q      <= rdy_d;
            rd_q       <= rd_d;
            rdy_new_q  <= rdy_new_d;
            rd_valid_q <= rd_valid_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
        end
    end

    assign wr_idx   = wr_q;
    assign rd_idx   = rd_q;
    assign wr_base  = wr_base_q;
    assign rd_base  = rd_base_q;
    assign rd_valid = rd_valid_q;

`ifdef TRIBUF_STATS_EN
    tribuf_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk_i (ACLK),
        .rst_i (ARESET),
        .clr_i (stat_clr),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt)
    );

    tribuf_sat_cnt #(.CNT_W(CNT_W)) u_rep_cnt (
        .clk_i (ACLK),
        .rst_i (ARESET),
        .clr_i (stat_clr),
        .inc_i (rep_inc),
        .cnt_o (rep_cnt)
    );
`else
    logic unused_stats;
    assign unused_stats = stat_clr ^ drop_inc ^ rep_inc;
    assign drop_cnt     = '0;
    assign rep_cnt      = '0;
`endif

endmodule

// File: tb/tb_tribuf_ctrl.sv
// Directed bench for tribuf_ctrl; counter expectations follow TRIBUF_STATS_EN.
module tb_tribuf_ctrl;
    import tribuf_pkg::*;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 3;
`ifdef TRIBUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              cfg_en;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_frame_bytes;
    logic              stat_clr;
    logic              wr_done;
    logic              rd_swap;
    logic [1:0]        wr_idx, rd_idx;
    logic [ADDR_W-1:0] wr_base, rd_base;
    logic              rd_valid;
    logic [CNT_W-1:0]  drop_cnt, rep_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 ACLK = ~ACLK;

    tribuf_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .ACLK            (ACLK),
        .ARESET          (ARESET),
        .cfg_en          (cfg_en),
        .cfg_base        (cfg_base),
        .cfg_frame_bytes (cfg_frame_bytes),
        .stat_clr        (stat_clr),
        .wr_done         (wr_done),
        .rd_swap         (rd_swap),
        .wr_idx          (wr_idx),
        .rd_idx          (rd_idx),
        .wr_base         (wr_base),
        .rd_base         (rd_base),
        .rd_valid        (rd_valid),
        .drop_cnt        (drop_cnt),
        .rep_cnt         (rep_cnt)
    );

    function automatic logic [63:0] ec(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Holds the pulses across exactly one rising edge, returns at the next falling edge.
    task automatic step(input logic wd, input logic rs, input logic clr);
        wr_done  = wd;
        rd_swap  = rs;
        stat_clr = clr;
        @(negedge ACLK);
        wr_done  = 1'b0;
        rd_swap  = 1'b0;
        stat_clr = 1'b0;
    endtask

    initial begin
        ARESET          = 1'b1;
        cfg_en          = 1'b0;
        cfg_base        = '0;
        cfg_frame_bytes = '0;
        stat_clr        = 1'b0;
        wr_done         = 1'b0;
        rd_swap         = 1'b0;
        repeat (2) @(negedge ACLK);

        chk("rst_wr_idx",   wr_idx,   0);
        chk("rst_rd_idx",   rd_idx,   2);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_drop",     drop_cnt, 0);
        chk("rst_rep",      rep_cnt,  0);
        chk("rst_wr_base",  wr_base,  0);
        chk("rst_rd_base",  rd_base,  0);

        ARESET          = 1'b0;
        cfg_en          = 1'b1;
        cfg_base        = 32'h1000_0000;
        cfg_frame_bytes = 32'h0000_1000;
        repeat (3) step(0, 0, 0);
        chk("init_wr_base",  wr_base,  32'h1000_0000);
        chk("init_rd_base",  rd_base,  32'h1000_2000);
        chk("init_rd_valid", rd_valid, 0);

        step(1, 0, 0);
        chk("lat_wr_idx",      wr_idx,  1);
        chk("lat_wr_base_old", wr_base, 32'h1000_0000);
        step(0, 1, 0);
        chk("lat_rd_idx",      rd_idx,  0);
        chk("lat_wr_base_new", wr_base, 32'h1000_1000);
        step(0, 0, 0);
        chk("first_rd_base",  rd_base,       32'h1000_0000);
        chk("first_rd_valid", rd_valid,      1);
        chk("first_wr_idx",   wr_idx,        1);
        chk("first_state",    dut.state_q,   ST_RUN);

        repeat (3) step(1, 0, 0);
        chk("drop_cnt2",   drop_cnt, ec(2));
        chk("drop_wr_idx", wr_idx,   2);
        chk("drop_rd_idx", rd_idx,   0);

        step(0, 1, 0);
        repeat (4) step(0, 1, 0);
        chk("rep_cnt4",   rep_cnt, ec(4));
        chk("rep_rd_idx", rd_idx,  1);
        step(0, 1, 1);
        chk("clr_rep",  rep_cnt,  0);
        chk("clr_drop", drop_cnt, 0);

        cfg_en = 1'b0;
        step(0, 0, 0);
        cfg_en = 1'b1;
        step(0, 0, 0);
        step(0, 1, 0);
        chk("prime_rep",      rep_cnt,     0);
        chk("prime_rd_idx",   rd_idx,      2);
        chk("prime_state",    dut.state_q, ST_PRIME);
        chk("prime_rd_valid", rd_valid,    0);

        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("pre_sim_wr_idx", wr_idx,   1);
        chk("pre_sim_rd_idx", rd_idx,   0);
        chk("pre_sim_drop",   drop_cnt, ec(1));

        step(1, 1, 0);
        chk("sim_rd_idx",   rd_idx,    1);
        chk("sim_wr_idx",   wr_idx,    2);
        chk("sim_rdy_idx",  dut.rdy_q, 0);
        chk("sim_drop",     drop_cnt,  ec(1));
        chk("sim_rep",      rep_cnt,   0);
        chk("sim_rd_valid", rd_valid,  1);
        step(0, 0, 0);
        chk("sim_rd_base", rd_base, 32'h1000_1000);
        chk("sim_wr_base", wr_base, 32'h1000_2000);

        cfg_base = 32'h2000_0000;
        repeat (2) step(0, 0, 0);
        chk("cfg_rd_base", rd_base, 32'h2000_1000);
        chk("cfg_wr_idx",  wr_idx,  2);

        repeat (9) step(0, 1, 0);
        chk("sat_rep",  rep_cnt,  ec(7));
        chk("sat_drop", drop_cnt, ec(1));

        cfg_en = 1'b0;
        step(0, 0, 0);
        chk("dis_wr_idx",   wr_idx,      0);
        chk("dis_rd_idx",   rd_idx,      2);
        chk("dis_rd_valid", rd_valid,    0);
        chk("dis_state",    dut.state_q, ST_IDLE);

        #3;
        wr_done = 1'b1;
        ARESET  = 1'b1;
        #1;
        chk("arst_drop",     drop_cnt,    0);
        chk("arst_rep",      rep_cnt,     0);
        chk("arst_wr_base",  wr_base,     0);
        chk("arst_rd_base",  rd_base,     0);
        chk("arst_wr_idx",   wr_idx,      0);
        chk("arst_rd_idx",   rd_idx,      2);
        chk("arst_rdy_new",  dut.rdy_new_q, 0);
        chk("arst_state",    dut.state_q, ST_IDLE);
        @(negedge ACLK);
        wr_done = 1'b0;
        chk("arst_hold_rd_valid", rd_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tribuf_ctrl.md
TRIBUF_CTRL -- requirements
Module: tribuf_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of buffer base addresses and of cfg_base/cfg_frame_bytes.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 ACLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 ARESET  input  1  reset, asynchronous assertion, active-high.
REQ-005 cfg_en  input  1  enable from AXI4-Lite control register 0; low forces IDLE.
REQ-006 cfg_base  input  ADDR_W  base address of buffer 0 (register 1).
REQ-007 cfg_frame_bytes  input  ADDR_W  byte stride between buffers (register 2).
REQ-008 stat_clr  input  1  single-cycle pulse clearing statistics (register 3 write strobe).
REQ-009 wr_done  input  1  single-cycle pulse: writer finished filling the current write buffer.
REQ-010 rd_swap  input  1  single-cycle pulse: reader at frame boundary, requests the next buffer.
REQ-011 wr_idx / rd_idx  output  2 each  buffer index owned by writer / reader (0..2).
REQ-012 wr_base / rd_base  output  ADDR_W each  cfg_base + idx*cfg_frame_bytes, registered, modulo 2^ADDR_W.
REQ-013 rd_valid  output  1  reader buffer holds a completed frame.
REQ-014 drop_cnt / rep_cnt  output  CNT_W each  dropped-frame / repeated-frame counters.

Function
REQ-015 Three indices wr/rdy/rd SHALL always be a permutation of {0,1,2}; an internal flag rdy_new marks the rdy buffer as unread.
REQ-016 States: IDLE, PRIME, RUN; IDLE->PRIME when cfg_en=1; PRIME->RUN on the first rd_swap with rdy_new=1; any state->IDLE when cfg_en=0.
REQ-017 In IDLE: indices return to wr=0, rdy=1, rd=2, rdy_new=0, rd_valid=0; wr_done and rd_swap ignored.
REQ-018 wr_done alone (PRIME/RUN): swap wr and rdy, set rdy_new=1; if rdy_new was already 1, increment drop_cnt.
REQ-019 rd_swap alone with rdy_new=1: swap rd and rdy, clear rdy_new, set rd_valid=1.
REQ-020 rd_swap alone with rdy_new=0: indices unchanged; in RUN increment rep_cnt; in PRIME no count.
REQ-021 wr_done and rd_swap in the same cycle: new rd = old wr, new wr = old rdy, new rdy = old rd, rdy_new=0, rd_valid=1; drop_cnt and rep_cnt unchanged.
REQ-022 Index changes visible on wr_idx/rd_idx one cycle after the pulse; wr_base/rd_base one cycle after the index (latency 2).
REQ-023 Counters saturate at all-ones; stat_clr zeros both and has priority over a same-cycle increment.
REQ-024 cfg_base/cfg_frame_bytes changes take effect on the next base recompute without disturbing indices.

Reset
REQ-025 On ARESET: state IDLE, wr_idx=0, rd_idx=2, internal rdy=1, rdy_new=0, rd_valid=0, drop_cnt=0, rep_cnt=0, wr_base=0, rd_base=0.
REQ-026 Reset asserted mid-frame SHALL abandon pending pulses; no counter update occurs in the reset cycle.

Configuration
REQ-027 Macro TRIBUF_STATS_EN: defined -> drop_cnt/rep_cnt and stat_clr function per REQ-018..023; undefined -> counters tied to 0, stat_clr ignored, ports retained.

Structure
REQ-028 Package tribuf_pkg holds buf_idx_t (2-bit), state enum (IDLE/PRIME/RUN) and reset index constants.
REQ-029 One sub-module tribuf_sat_cnt (saturating counter with clear/increment), instantiated twice under TRIBUF_STATS_EN.

Verification
REQ-030 Reset, cfg_en=1, cfg_base=0x1000_0000, cfg_frame_bytes=0x1000 -> wr_base=0x1000_0000, rd_base=0x1000_2000, rd_valid=0.
REQ-031 wr_done then rd_swap -> wr_idx=1, rd_idx=0, rd_valid=1, rd_base=0x1000_0000, state RUN.
REQ-032 In RUN, three wr_done with no rd_swap -> drop_cnt=2, indices still a permutation.
REQ-033 In RUN, rd_swap with rdy_new=0 four times -> rep_cnt=4; then stat_clr coincident with rd_swap -> rep_cnt=0.
REQ-034 wr_done and rd_swap same cycle from wr=1,rdy=2,rd=0,rdy_new=1 -> rd=1, wr=2, rdy=0, counters unchanged.
REQ-035 cfg_en low mid-RUN, then ARESET asserted asynchronously -> IDLE, outputs at REQ-025 values with TRIBUF_STATS_EN both defined and undefined.
